// File: rtl/branch_pkg.sv
// Shared definitions for the execute-stage branch resolver: control-flow
// opcodes, resolver FSM encoding and the redirect-cause classification.
package branch_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        NONE          = 3'd0,
        PRED_T_ACT_NT = 3'd1,
        PRED_NT_ACT_T = 3'd2,
        TGT_MISMATCH  = 3'd3,
        ALIAS         = 3'd4
    } cause_t;

    // True for the opcodes whose outcome trains the predictor (B-type, JAL).
    function automatic logic is_ctrl_opcode(input logic [6:0] opcode);
        return (opcode == OPC_BRANCH) || (opcode == OPC_JAL);
    endfunction

endpackage

// File: rtl/branch_pred_pipe.sv
// Two-stage carrier for the fetch-time prediction (taken bit + target),
// moving F->D->E alongside the instruction. Flush wins over stall.
module branch_pred_pipe (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        StallE,
    input  logic        FlushE,
    input  logic        predict_F,
    input  logic [31:0] pred_target_F,
    output logic        pred_E,
    output logic [31:0] pred_target_E
);

    logic        pred_p1;
    logic [31:0] tgt_p1;
    logic        pred_p2;
    logic [31:0] tgt_p2;

    // F -> D: decode-stage copy of the prediction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pred_p1 <= 1'b0;
            tgt_p1  <= '0;
        end else if (FlushD) begin
            pred_p1 <= 1'b0;
            tgt_p1  <= '0;
        end else if (!StallD) begin
            pred_p1 <= predict_F;
            tgt_p1  <= pred_target_F;
        end
    end

    // D -> E: execute-stage copy compared against the actual outcome
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pred_p2 <= 1'b0;
            tgt_p2  <= '0;
        end else if (FlushE) begin
            pred_p2 <= 1'b0;
            tgt_p2  <= '0;
        end else if (!StallE) begin
            pred_p2 <= pred_p1;
            tgt_p2  <= tgt_p1;
        end
    end

    assign pred_E        = pred_p2;
    assign pred_target_E = tgt_p2;

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: compares the carried fetch prediction with
// the actual outcome, raises redirect/flush and emits the one-cycle predictor
// training update. Define BRANCH_RESOLVER_PERF_EN to add saturating
// branch/mispredict performance counters (cnt_branch, cnt_mispred).
module branch_resolver
    import branch_pkg::*;
#(
    parameter int unsigned RECOVER_CYCLES = 1,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic             predict_F,
    input  logic [31:0]      pred_target_F,
    input  logic             branch_E,
    input  logic             PCSrcE,
    input  logic [31:0]      Act_TargetE,
    input  logic [31:0]      PCPlus4E,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic             flush_req,
    output logic             upd_valid,
    output logic             upd_taken,
    output logic [31:0]      upd_target
`ifdef BRANCH_RESOLVER_PERF_EN
    ,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_mispred
`endif
);

    if (RECOVER_CYCLES < 1 || RECOVER_CYCLES > 3 || CNT_W < 1) begin : g_param_check
        $error("branch_resolver: RECOVER_CYCLES must be 1..3 and CNT_W >= 1");
    end

    localparam logic [1:0] RCNT_INIT = 2'(RECOVER_CYCLES - 1);

    state_t      state;
    logic [1:0]  rcnt;
    cause_t      cause;
    logic        compare_en;
    logic        pred_E;
    logic [31:0] pred_target_E;

    branch_pred_pipe u_pipe (
        .clk           (clk),
        .reset_n       (reset_n),
        .StallD        (StallD),
        .FlushD        (FlushD),
        .StallE        (StallE),
        .FlushE        (FlushE),
        .predict_F     (predict_F),
        .pred_target_F (pred_target_F),
        .pred_E        (pred_E),
        .pred_target_E (pred_target_E)
    );

    // Classify the E-stage outcome against the carried prediction
    always_comb begin
        cause = NONE;
        if (branch_E) begin
            if (pred_E && !PCSrcE)
                cause = PRED_T_ACT_NT;
            else if (!pred_E && PCSrcE)
                cause = PRED_NT_ACT_T;
            else if (pred_E && PCSrcE && (pred_target_E != Act_TargetE))
                cause = TGT_MISMATCH;
        end else if (pred_E) begin
            // Predictor hit on a non-control instruction: fall through, no training.
            cause = ALIAS;
        end
    end

    // Outputs are forced quiet while reset is held so an asynchronous reset
    // silences them immediately, even mid-recovery.
    assign compare_en = reset_n && (state == IDLE) && !StallE;
    assign mispredict = compare_en && (cause != NONE);
    assign flush_req  = mispredict || (state == RECOVER);
    assign upd_valid  = compare_en && branch_E;
    assign upd_taken  = reset_n && PCSrcE;
    assign upd_target = reset_n ? Act_TargetE : '0;

    // Select the redirect address: taken-side causes go to the actual target
    always_comb begin
        redirect_pc = PCPlus4E;
        if (!reset_n)
            redirect_pc = '0;
        else if ((cause == PRED_NT_ACT_T) || (cause == TGT_MISMATCH))
            redirect_pc = Act_TargetE;
    end

    // Recovery FSM: mask compare/training for RECOVER_CYCLES after a redirect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mispredict) begin
                        state <= RECOVER;
                        rcnt  <= RCNT_INIT;
                    end
                end
                RECOVER: begin
                    if (rcnt == 2'd0)
                        state <= IDLE;
                    else
                        rcnt <= rcnt - 2'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRANCH_RESOLVER_PERF_EN
    // Saturating counters of resolved branches and mispredicts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_branch  <= '0;
            cnt_mispred <= '0;
        end else begin
            if (upd_valid && (cnt_branch != '1))
                cnt_branch <= cnt_branch + 1'b1;
            if (mispredict && (cnt_mispred != '1))
                cnt_mispred <= cnt_mispred + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: reset, the three mispredict causes,
// aliasing, correct prediction, stall/flush corner cases, reset mid-recovery
// and, when BRANCH_RESOLVER_PERF_EN is defined, the saturating counters.
module tb_branch_resolver;

    localparam int unsigned CNT_W_TB = 4;

    logic        clk;
    logic        reset_n;
    logic        StallD, FlushD, StallE, FlushE;
    logic        predict_F;
    logic [31:0] pred_target_F;
    logic        branch_E, PCSrcE;
    logic [31:0] Act_TargetE, PCPlus4E;
    logic        mispredict, flush_req, upd_valid, upd_taken;
    logic [31:0] redirect_pc, upd_target;
`ifdef BRANCH_RESOLVER_PERF_EN
    logic [CNT_W_TB-1:0] cnt_branch, cnt_mispred;
`endif

    int checks = 0;
    int errors = 0;

    branch_resolver #(.RECOVER_CYCLES(1), .CNT_W(CNT_W_TB)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .StallD        (StallD),
        .FlushD        (FlushD),
        .StallE        (StallE),
        .FlushE        (FlushE),
        .predict_F     (predict_F),
        .pred_target_F (pred_target_F),
        .branch_E      (branch_E),
        .PCSrcE        (PCSrcE),
        .Act_TargetE   (Act_TargetE),
        .PCPlus4E      (PCPlus4E),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc),
        .flush_req     (flush_req),
        .upd_valid     (upd_valid),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target)
`ifdef BRANCH_RESOLVER_PERF_EN
        ,
        .cnt_branch    (cnt_branch),
        .cnt_mispred   (cnt_mispred)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_e();
        branch_E = 1'b0; PCSrcE = 1'b0; Act_TargetE = '0; PCPlus4E = '0;
        StallD = 1'b0; FlushD = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    endtask

    // Place a prediction in E two edges later; the first edge also retires
    // whatever the previous E-stage inputs were.
    task automatic launch(input logic p, input logic [31:0] t);
        predict_F = p; pred_target_F = t;
        tick();
        predict_F = 1'b0; pred_target_F = '0;
        clr_e();
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        clr_e();
        predict_F = 1'b0; pred_target_F = '0;
        #1 reset_n = 1'b0;
        branch_E = 1'b1; PCSrcE = 1'b1; Act_TargetE = 32'h55; PCPlus4E = 32'h66;
        tick(); tick();
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict got %b want 0", mispredict); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect got %h want 0", redirect_pc); end
        checks++; if (flush_req !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", flush_req); end
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL reset_upd_valid got %b want 0", upd_valid); end
        checks++; if (upd_taken !== 1'b0) begin errors++; $display("FAIL reset_upd_taken got %b want 0", upd_taken); end
        checks++; if (upd_target !== 32'h0) begin errors++; $display("FAIL reset_upd_target got %h want 0", upd_target); end
        reset_n = 1'b1;
        clr_e();
        tick();
    endtask

    task automatic test_pred_t_act_nt();
        launch(1'b1, 32'h100);
        branch_E = 1'b1; PCSrcE = 1'b0; PCPlus4E = 32'h44; Act_TargetE = 32'h100;
        #1;
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL tnt_mispredict got %b want 1", mispredict); end
        checks++; if (redirect_pc !== 32'h44) begin errors++; $display("FAIL tnt_redirect got %h want 44", redirect_pc); end
        checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL tnt_upd_valid got %b want 1", upd_valid); end
        checks++; if (upd_taken !== 1'b0) begin errors++; $display("FAIL tnt_upd_taken got %b want 0", upd_taken); end
        checks++; if (flush_req !== 1'b1) begin errors++; $display("FAIL tnt_flush got %b want 1", flush_req); end
    endtask

    task automatic test_pred_nt_act_t();
        launch(1'b0, 32'h0);
        branch_E = 1'b1; PCSrcE = 1'b1; Act_TargetE = 32'h200; PCPlus4E = 32'h48;
        #1;
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL ntt_mispredict got %b want 1", mispredict); end
        checks++; if (redirect_pc !== 32'h200) begin errors++; $display("FAIL ntt_redirect got %h want 200", redirect_pc); end
        checks++; if (upd_taken !== 1'b1) begin errors++; $display("FAIL ntt_upd_taken got %b want 1", upd_taken); end
        tick();
        checks++; if (flush_req !== 1'b1) begin errors++; $display("FAIL recover_flush got %b want 1", flush_req); end
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL recover_masked got %b want 0", mispredict); end
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL recover_upd_valid got %b want 0", upd_valid); end
        clr_e();
        tick();
        checks++; if (flush_req !== 1'b0) begin errors++; $display("FAIL recover_exit_flush got %b want 0", flush_req); end
    endtask

    task automatic test_target();
        launch(1'b1, 32'h100);
        branch_E = 1'b1; PCSrcE = 1'b1; Act_TargetE = 32'h104; PCPlus4E = 32'h4C;
        #1;
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL tgt_mispredict got %b want 1", mispredict); end
        checks++; if (redirect_pc !== 32'h104) begin errors++; $display("FAIL tgt_redirect got %h want 104", redirect_pc); end
        launch(1'b1, 32'h100);
        branch_E = 1'b1; PCSrcE = 1'b1; Act_TargetE = 32'h100; PCPlus4E = 32'h50;
        #1;
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL hit_mispredict got %b want 0", mispredict); end
        checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL hit_upd_valid got %b want 1", upd_valid); end
        checks++; if (upd_target !== 32'h100) begin errors++; $display("FAIL hit_upd_target got %h want 100", upd_target); end
        checks++; if (flush_req !== 1'b0) begin errors++; $display("FAIL hit_flush got %b want 0", flush_req); end
        clr_e();
        tick();
    endtask

    task automatic test_stall_e();
        launch(1'b1, 32'h300);
        StallE = 1'b1; branch_E = 1'b1; PCSrcE = 1'b0; PCPlus4E = 32'h80; Act_TargetE = 32'h300;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL stall_mispredict cyc %0d got %b want 0", i, mispredict); end
            checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL stall_upd_valid cyc %0d got %b want 0", i, upd_valid); end
            tick();
        end
        StallE = 1'b0;
        #1;
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL stall_release got %b want 1", mispredict); end
        checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL stall_redirect got %h want 80", redirect_pc); end
        tick(); tick();
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL stall_single_pulse got %b want 0", mispredict); end
        clr_e();
        tick();
    endtask

    task automatic test_flush_d_alias();
        predict_F = 1'b1; pred_target_F = 32'h500;
        tick();
        predict_F = 1'b0; pred_target_F = '0;
        StallD = 1'b1; FlushD = 1'b1; StallE = 1'b1;
        tick();
        clr_e();
        tick();
        PCPlus4E = 32'h90;
        #1;
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL flushd_mispredict got %b want 0", mispredict); end
        checks++; if (flush_req !== 1'b0) begin errors++; $display("FAIL flushd_flush got %b want 0", flush_req); end
        launch(1'b1, 32'h500);
        PCPlus4E = 32'h94; Act_TargetE = 32'h777;
        #1;
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL alias_mispredict got %b want 1", mispredict); end
        checks++; if (redirect_pc !== 32'h94) begin errors++; $display("FAIL alias_redirect got %h want 94", redirect_pc); end
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL alias_upd_valid got %b want 0", upd_valid); end
        clr_e();
        tick(); tick();
    endtask

    task automatic test_flush_e();
        predict_F = 1'b1; pred_target_F = 32'h600;
        tick(); tick();
        predict_F = 1'b0; pred_target_F = '0;
        branch_E = 1'b1; PCSrcE = 1'b0; PCPlus4E = 32'hA0; Act_TargetE = 32'h600; FlushE = 1'b1;
        #1;
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL flushe_mispredict got %b want 1", mispredict); end
        checks++; if (redirect_pc !== 32'hA0) begin errors++; $display("FAIL flushe_redirect got %h want a0", redirect_pc); end
        tick();
        clr_e();
        StallE = 1'b1;
        tick();
        StallE = 1'b0;
        #1;
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL flushe_cleared got %b want 0", mispredict); end
        tick();
    endtask

    task automatic test_reset_mid_recover();
        launch(1'b1, 32'h700);
        branch_E = 1'b1; PCSrcE = 1'b0; PCPlus4E = 32'hB0; Act_TargetE = 32'h700;
        #1;
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL rmid_mispredict got %b want 1", mispredict); end
        tick();
        checks++; if (flush_req !== 1'b1) begin errors++; $display("FAIL rmid_recover got %b want 1", flush_req); end
        PCSrcE = 1'b1; Act_TargetE = 32'h123;
        #1 reset_n = 1'b0;
        #1;
        checks++; if (flush_req !== 1'b0) begin errors++; $display("FAIL rmid_flush got %b want 0", flush_req); end
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL rmid_mis got %b want 0", mispredict); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rmid_redirect got %h want 0", redirect_pc); end
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL rmid_upd_valid got %b want 0", upd_valid); end
        checks++; if (upd_taken !== 1'b0) begin errors++; $display("FAIL rmid_upd_taken got %b want 0", upd_taken); end
        checks++; if (upd_target !== 32'h0) begin errors++; $display("FAIL rmid_upd_target got %h want 0", upd_target); end
        tick();
        reset_n = 1'b1;
        clr_e();
        #1;
        checks++; if (flush_req !== 1'b0) begin errors++; $display("FAIL rmid_idle got %b want 0", flush_req); end
        tick();
    endtask

`ifdef BRANCH_RESOLVER_PERF_EN
    task automatic test_perf();
        reset_n = 1'b0;
        #1;
        checks++; if (cnt_mispred !== 4'd0) begin errors++; $display("FAIL perf_reset_mis got %0d want 0", cnt_mispred); end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            launch(1'b1, 32'h800);
            branch_E = 1'b1; PCSrcE = 1'b0; PCPlus4E = 32'hC0; Act_TargetE = 32'h800;
            #1;
            if (i == 5) begin
                checks++; if (cnt_mispred !== 4'd5) begin errors++; $display("FAIL perf_mis5 got %0d want 5", cnt_mispred); end
                checks++; if (cnt_branch !== 4'd5) begin errors++; $display("FAIL perf_br5 got %0d want 5", cnt_branch); end
            end
        end
        tick();
        clr_e();
        checks++; if (cnt_mispred !== 4'd15) begin errors++; $display("FAIL perf_mis_sat got %0d want 15", cnt_mispred); end
        checks++; if (cnt_branch !== 4'd15) begin errors++; $display("FAIL perf_br_sat got %0d want 15", cnt_branch); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (cnt_mispred !== 4'd0) begin errors++; $display("FAIL perf_async_mis got %0d want 0", cnt_mispred); end
        checks++; if (cnt_branch !== 4'd0) begin errors++; $display("FAIL perf_async_br got %0d want 0", cnt_branch); end
        tick();
        reset_n = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_pred_t_act_nt();
        test_pred_nt_act_t();
        test_target();
        test_stall_e();
        test_flush_d_alias();
        test_flush_e();
        test_reset_mid_recover();
`ifdef BRANCH_RESOLVER_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
